// File: rtl/dense_res_writer.sv
// Packs adder-tree results PACK-wide into BRAM words and writes them out,
// zero-padding the final partial word and pulsing done at the end of a pass.
module dense_res_writer #(
  parameter int DATA_W  = 16,
  parameter int PACK    = 4,
  parameter int NUM_RES = 250,
  parameter int ADDR_W  = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   data_v,
  input  logic [DATA_W-1:0]      in_res_w,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W*PACK-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW = $clog2(NUM_RES + 1);
  localparam int WW = DATA_W * PACK;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_n;

  logic [LW-1:0]     lane_idx;
  logic [CW-1:0]     res_cnt;
  logic [ADDR_W-1:0] waddr;
  logic [WW-1:0]     lanes;
  logic [WW-1:0]     pend_word;
  logic [WW-1:0]     word_c;
  logic              pending;

  logic full;
  logic last_res;
  logic last_lane;
  logic accept;
  logic issue;
  logic flush_go;
  logic go;

  assign full      = res_cnt == CW'(NUM_RES);
  assign last_res  = res_cnt == CW'(NUM_RES - 1);
  assign last_lane = lane_idx == LW'(PACK - 1);
  assign accept    = (state == RUN) && data_v && !halt && !full;
  assign issue     = pending && !halt;
  assign flush_go  = (state == FLUSH) && (lane_idx != '0) && !halt;
  assign go        = (state == IDLE) && start;

  assign busy = (state == RUN) || (state == FLUSH);
  assign done = state == DONE;

  always_comb begin
    word_c = lanes;
    word_c[lane_idx*DATA_W +: DATA_W] = in_res_w;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        if (accept && last_res && !last_lane)
          state_n = FLUSH;
        else if (full && !pending)
          state_n = DONE;
      end
      FLUSH: begin
        if ((lane_idx == '0) && !pending)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx  <= '0;
      res_cnt   <= '0;
      waddr     <= '0;
      lanes     <= '0;
      pend_word <= '0;
      pending   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err       <= 1'b0;
    end else begin
      wr_en <= issue;
      if (issue) begin
        wr_data <= pend_word;
        wr_addr <= waddr;
        waddr   <= waddr + ADDR_W'(1);
        pending <= 1'b0;
      end
      // lanes are kept zeroed past the fill point so a flush pads for free
      if (accept) begin
        res_cnt <= res_cnt + CW'(1);
        if (last_lane) begin
          pend_word <= word_c;
          pending   <= 1'b1;
          lanes     <= '0;
          lane_idx  <= '0;
        end else begin
          lanes    <= word_c;
          lane_idx <= lane_idx + LW'(1);
        end
      end
      if (flush_go) begin
        pend_word <= lanes;
        pending   <= 1'b1;
        lanes     <= '0;
        lane_idx  <= '0;
      end
      if (data_v && (state != RUN))
        err <= 1'b1;
      if (go) begin
        lane_idx <= '0;
        res_cnt  <= '0;
        waddr    <= '0;
        lanes    <= '0;
        err      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dense_res_writer.sv
// Randomized bench for dense_res_writer: scoreboards every BRAM write
// against words packed from the accepted-result list.
module tb_dense_res_writer;

  localparam int DW = 16;
  localparam int P  = 4;
  localparam int N  = 250;
  localparam int AW = 7;
  localparam int SN = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          halt;
  logic          data_v;
  logic [DW-1:0] in_res_w;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;

  logic          s_start;
  logic          s_halt;
  logic          s_data_v;
  logic [DW-1:0] s_in;
  logic          s_wr_en;
  logic [AW-1:0] s_wr_addr;
  logic [63:0]   s_wr_data;
  logic          s_busy;
  logic          s_done;
  logic          s_err;

  dense_res_writer #(
    .DATA_W(DW), .PACK(P), .NUM_RES(N), .ADDR_W(AW)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .data_v(data_v), .in_res_w(in_res_w),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  dense_res_writer #(
    .DATA_W(DW), .PACK(P), .NUM_RES(SN), .ADDR_W(AW)
  ) u_small (
    .clk(clk), .rst(rst), .start(s_start), .halt(s_halt),
    .data_v(s_data_v), .in_res_w(s_in),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .busy(s_busy), .done(s_done), .err(s_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] got_a[$];
  logic [63:0]   got_d[$];
  int            got_c[$];
  int            done_n, done_c, done_busy;
  logic [63:0]   s_got_d[$];
  logic [AW-1:0] s_got_a[$];
  int            s_got_c[$];
  int            s_done_n, s_done_c;

  always @(negedge clk) begin
    if (wr_en) begin
      got_a.push_back(wr_addr);
      got_d.push_back(wr_data);
      got_c.push_back(cyc);
    end
    if (done) begin
      done_n++;
      done_c = cyc;
      if (busy) done_busy++;
    end
    if (s_wr_en) begin
      s_got_a.push_back(s_wr_addr);
      s_got_d.push_back(s_wr_data);
      s_got_c.push_back(cyc);
    end
    if (s_done) begin
      s_done_n++;
      s_done_c = cyc;
    end
  end

  logic [DW-1:0] acc[$];

  // word i holds results i*P..i*P+P-1, missing tail results read as zero
  function automatic logic [63:0] exp_word(input int i);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < P; k++)
      if (i*P + k < acc.size()) w[k*DW +: DW] = acc[i*P + k];
    return w;
  endfunction

  task automatic clear_mon();
    got_a.delete();
    got_d.delete();
    got_c.delete();
    done_n    = 0;
    done_c    = 0;
    done_busy = 0;
  endtask

  task automatic step(input logic dv, input logic h, input logic [DW-1:0] v);
    data_v   = dv;
    halt     = h;
    in_res_w = v;
    if (dv && !h) acc.push_back(v);
    @(posedge clk);
    #1;
  endtask

  // mode 0: consecutive 1..N then one data_v in FLUSH
  // mode 1: random values, gaps and halts
  // mode 2: consecutive with a 3-cycle halt after the 4th result
  task automatic drive_pass(input int mode, input logic exp_err);
    int guard;
    acc.delete();
    clear_mon();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (mode == 2) begin
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, DW'(i));
      data_v   = 1'b1;
      halt     = 1'b1;
      in_res_w = 16'hdead;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("wr_en_in_halt", 64'(wr_en), 64'd0);
        @(posedge clk); #1;
      end
      step(1'b0, 1'b0, '0);
      @(negedge clk);
      check("halt_wr_en", 64'(wr_en), 64'd1);
      check("halt_addr", 64'(wr_addr), 64'd0);
      check("halt_data", wr_data, 64'h0004_0003_0002_0001);
      @(posedge clk); #1;
    end
    guard = 0;
    while (acc.size() < N && guard < 5000) begin
      guard++;
      if (mode == 1)
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
             DW'($urandom));
      else
        step(1'b1, 1'b0, DW'(acc.size() + 1));
    end
    if (mode == 0) begin
      data_v   = 1'b1;
      in_res_w = 16'hbeef;
      @(posedge clk); #1;
    end
    data_v = 1'b0;
    halt   = 1'b0;
    guard  = 0;
    while (done_n == 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (done_n == 0) check("done_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("n_writes", 64'(got_a.size()), 64'((acc.size() + P - 1) / P));
    for (int i = 0; i < got_a.size(); i++) begin
      check("wr_addr", 64'(got_a[i]), 64'(i));
      check("wr_data", got_d[i], exp_word(i));
    end
    check("done_once", 64'(done_n), 64'd1);
    check("busy_at_done", 64'(done_busy), 64'd0);
    if (got_c.size() > 0)
      check("done_lag", 64'(done_c), 64'(got_c[got_c.size()-1] + 1));
    check("err_end", 64'(err), 64'(exp_err));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    halt     = 1'b0;
    data_v   = 1'b0;
    in_res_w = '0;
    s_start  = 1'b0;
    s_halt   = 1'b0;
    s_data_v = 1'b0;
    s_in     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);

    drive_pass(0, 1'b1);
    if (got_d.size() > 62) begin
      check("word0", got_d[0], 64'h0004_0003_0002_0001);
      check("word62", got_d[62], 64'h0000_0000_00fa_00f9);
    end

    drive_pass(2, 1'b0);
    drive_pass(1, 1'b0);

    clear_mon();
    @(posedge clk); #1 data_v = 1'b1;
    @(posedge clk); #1 data_v = 1'b0;
    @(negedge clk);
    check("idle_err", 64'(err), 64'd1);
    check("idle_no_write", 64'(got_a.size()), 64'd0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_clr_err", 64'(err), 64'd0);
    check("start_busy", 64'(busy), 64'd1);

    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(16'h100 + i));
    data_v = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_wr_en", 64'(wr_en), 64'd0);
    check("mid_rst_addr", 64'(wr_addr), 64'd0);
    check("mid_rst_data", wr_data, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    check("post_rst_wr_en", 64'(wr_en), 64'd0);
    drive_pass(1, 1'b0);

    s_got_a.delete();
    s_got_d.delete();
    s_got_c.delete();
    s_done_n = 0;
    acc.delete();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int i = 0; i < SN; i++) begin
      s_data_v = 1'b1;
      s_in     = DW'($urandom);
      acc.push_back(s_in);
      @(posedge clk); #1;
    end
    s_data_v = 1'b0;
    for (int g = 0; g < 40 && s_done_n == 0; g++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("small_n_writes", 64'(s_got_a.size()), 64'd2);
    for (int i = 0; i < s_got_a.size(); i++) begin
      check("small_addr", 64'(s_got_a[i]), 64'(i));
      check("small_data", s_got_d[i], exp_word(i));
    end
    check("small_done_once", 64'(s_done_n), 64'd1);
    if (s_got_c.size() > 0)
      check("small_done_lag", 64'(s_done_c),
            64'(s_got_c[s_got_c.size()-1] + 1));
    check("small_err", 64'(s_err), 64'd0);
    check("small_busy", 64'(s_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
